// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: default register-file geometry and
// the architectural register address type.
package riscv_pkg;

    // Default data width of one architectural register.
    localparam int WIDTH_DEF    = 32;

    // Default number of architectural registers (x0..x31).
    localparam int NUM_REGS_DEF = 32;

    // Address width that follows from the default register count.
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    // Architectural register index at the default geometry.
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    // One register value at the default geometry.
    typedef logic [WIDTH_DEF-1:0]  word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-result scoreboard: one busy bit per register plus a registered
// count of busy bits. Issue marks a destination busy and writeback clears it.
// A same-edge issue and writeback to one register leaves it busy, because the
// newer producer has not written back yet. Register 0 is never tracked.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [ADDR_W:0]     cnt_next;
    logic                wr_v;
    logic                iss_v;
    logic                set_new;
    logic                clr_new;

    assign wr_v  = wr_en    && (wr_addr  != '0);
    assign iss_v = issue_en && (issue_rd != '0);

    // Next busy vector and the count change it implies.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        busy_next = busy;
        cnt_next  = pending_cnt;
        // A bit is newly set only if it was idle. A bit is newly cleared only
        // if it was busy and is not being re-issued on the same edge.
        set_new   = iss_v && !busy[issue_rd];
        clr_new   = wr_v && busy[wr_addr] && !(iss_v && (issue_rd == wr_addr));
        if (wr_v) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (iss_v) begin
            busy_next[issue_rd] = 1'b1;
        end
        if (set_new && !clr_new) begin
            cnt_next = pending_cnt + CNT_ONE;
        end else if (clr_new && !set_new) begin
            cnt_next = pending_cnt - CNT_ONE;
        end
    end

    // Busy bits and pending count; both are cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value, whatever order the statements run in.
        if (!rst) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_next;
            pending_cnt <= cnt_next;
        end
    end

    // Read-port hazard flags. A writeback on this cycle already resolves the
    // hazard, so a consumer does not need to wait for the next edge.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rst) begin
            rs1_busy = busy[rs1_addr] && !(wr_en && (wr_addr == rs1_addr));
            rs2_busy = busy[rs2_addr] && !(wr_en && (wr_addr == rs2_addr));
        end
    end

endmodule

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports with writeback bypass,
// one write port, a hardwired-zero x0, and a pending-result scoreboard for
// hazard detection.
module reg_file
    import riscv_pkg::*;
#(
    parameter  int WIDTH    = WIDTH_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [WIDTH-1:0]  rs1_data,
    output logic [WIDTH-1:0]  rs2_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              hazard,
    output logic [ADDR_W:0]   pending_cnt
);

    // Entry 0 is reset and never written, so it holds zero at all times.
    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             wr_v;

    assign wr_v = wr_en && (wr_addr != '0);

    // Register storage: one write per edge, all entries cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the array is reset on purpose. Reset must leave every register
        // reading zero without any clock, so it cannot become a RAM macro.
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_v) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: writeback bypass first, then storage. x0 reads zero. Both
    // ports read zero while reset is held, even if wr_en is driven.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rst) begin
            if (wr_v && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
            end else if (rs1_addr != '0) begin
                rs1_data = regs[rs1_addr];
            end
            if (wr_v && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
            end else if (rs2_addr != '0) begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .pending_cnt (pending_cnt)
    );

    assign hazard = rs1_busy || rs2_busy;

endmodule
